// File: rtl/snitch_wrr_scheduler.sv
// Weighted round-robin scheduler sharing one request port among NrPorts requesters,
// with burst locking and per-port outstanding-read credit tracking.
module snitch_wrr_scheduler #(
    parameter int unsigned NrPorts        = 4,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned WeightWidth    = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdWidth        = $clog2(NrPorts),
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NrPorts-1:0][WeightWidth-1:0] weight_i,
    input  logic [NrPorts-1:0]                  req_valid_i,
    output logic [NrPorts-1:0]                  req_ready_o,
    input  logic [NrPorts-1:0][DataWidth-1:0]   req_data_i,
    input  logic [NrPorts-1:0]                  req_last_i,
    input  logic [NrPorts-1:0]                  req_write_i,
    output logic                                req_valid_o,
    input  logic                                req_ready_i,
    output logic [DataWidth-1:0]                req_data_o,
    output logic                                req_last_o,
    output logic                                req_write_o,
    output logic [IdWidth-1:0]                  req_id_o,
    input  logic                                resp_valid_i,
    input  logic                                resp_ready_i,
    input  logic                                resp_last_i,
    input  logic [IdWidth-1:0]                  resp_id_i,
    output logic [NrPorts-1:0][CntWidth-1:0]    outstanding_o,
    output logic                                err_o
);

    localparam logic [0:0] StArb   = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);
    localparam logic [IdWidth-1:0]  LastId = IdWidth'(NrPorts - 1);

    logic [0:0]                       state_q, state_d;
    logic [IdWidth-1:0]               ptr_q, ptr_d;
    logic [IdWidth-1:0]               gnt_q, gnt_d;
    logic [WeightWidth-1:0]           budget_q, budget_d;
    logic                             mid_q, mid_d;
    logic [NrPorts-1:0][CntWidth-1:0] cnt_q, cnt_d;
    logic                             err_q, err_d;

    logic [NrPorts-1:0] elig;
    logic               win_found;
    logic [IdWidth-1:0] win_idx;
    logic [IdWidth-1:0] scan_idx;
    logic               in_grant;
    logic               open;
    logic               beat;
    logic               beat_last;
    logic               resp_fire;

    // A port may compete if it has a request and, for reads, credit left
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            elig[IdWidth'(i)] = req_valid_i[IdWidth'(i)] &
                                (req_write_i[IdWidth'(i)] | (cnt_q[IdWidth'(i)] < CntMax));
        end
    end

    // Round-robin scan starting at ptr
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NrPorts; k++) begin
            scan_idx = IdWidth'((32'(ptr_q) + k) % NrPorts);
            if (!win_found && elig[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign in_grant    = (state_q == StGrant);
    assign open        = mid_q | elig[gnt_q];
    assign req_valid_o = in_grant & req_valid_i[gnt_q] & open;
    assign req_data_o  = req_data_i[gnt_q];
    assign req_last_o  = req_last_i[gnt_q];
    assign req_write_o = req_write_i[gnt_q];
    assign req_id_o    = gnt_q;
    assign beat        = req_valid_o & req_ready_i;
    assign beat_last   = beat & req_last_o;
    assign resp_fire   = resp_valid_i & resp_ready_i & resp_last_i;

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

    // Upstream ready only reaches the granted port
    always_comb begin
        req_ready_o          = '0;
        req_ready_o[gnt_q]   = in_grant & req_ready_i & open;
    end

    // Grant state machine: next state
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        budget_d = budget_q;
        mid_d    = mid_q;
        case (state_q)
            StArb: begin
                if (win_found) begin
                    state_d  = StGrant;
                    gnt_d    = win_idx;
                    budget_d = weight_i[win_idx];
                    mid_d    = 1'b0;
                end
            end
            StGrant: begin
                if (beat) begin
                    mid_d = !req_last_o;
                end
                if ((beat_last && (budget_q == '0)) || (!mid_q && !elig[gnt_q])) begin
                    state_d = StArb;
                    ptr_d   = (gnt_q == LastId) ? '0 : gnt_q + IdWidth'(1);
                end else if (beat_last) begin
                    budget_d = budget_q - WeightWidth'(1);
                end
            end
            default: state_d = StArb;
        endcase
    end

    // Outstanding-read counters and sticky underflow error
    always_comb begin
        logic inc;
        logic dec;
        inc   = 1'b0;
        dec   = 1'b0;
        cnt_d = cnt_q;
        err_d = err_q;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            inc = beat_last & !req_write_o & (gnt_q == IdWidth'(i));
            dec = resp_fire & (resp_id_i == IdWidth'(i));
            if (inc && !dec) begin
                cnt_d[IdWidth'(i)] = cnt_q[IdWidth'(i)] + CntWidth'(1);
            end else if (dec && !inc) begin
                if (cnt_q[IdWidth'(i)] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[IdWidth'(i)] = cnt_q[IdWidth'(i)] - CntWidth'(1);
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StArb;
            ptr_q    <= '0;
            gnt_q    <= '0;
            budget_q <= '0;
            mid_q    <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            budget_q <= budget_d;
            mid_q    <= mid_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

endmodule
